cache_access_ctrl: RTL and testbench

// - Request-side controller sitting directly upstream of the way lookup stage.
// - Accepts one CPU read request at a time, splits the address into tag/index/offset and drives the tag and index to the lookup.
// - Consumes the hit, miss and one-hot hitWay result.
// - On a miss: picks a victim way, fetches the block over a memory handshake, pulses a one-cycle fill to the way arrays, then responds.

---
 rtl/cache_pkg.sv | 21 ++
 rtl/cache_access_ctrl_if.sv | 42 ++++
 rtl/victim_select.sv | 17 +
 rtl/cache_access_ctrl.sv | 110 +++++++++++
 tb/tb_cache_access_ctrl.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// cache_pkg: FSM state type and address field width helper shared by the
// cache access controller and its interface.
package cache_pkg;

    typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, MISS_WAIT, FILL, RESP} state_e;

    typedef struct packed {
        int offset_w;
        int index_w;
        int tag_w;
    } widths_t;

    function automatic widths_t calc_widths(input int addr_w, input int block_size, input int num_sets);
        widths_t w;
        w.offset_w = $clog2(block_size);
        w.index_w  = $clog2(num_sets);
        w.tag_w    = addr_w - w.offset_w - w.index_w;
        return w;
    endfunction

endpackage

// File: rtl/cache_access_ctrl_if.sv
// cache_access_ctrl_if: CPU request, way lookup, memory fetch, fill and
// response signals of the cache access controller.
interface cache_access_ctrl_if import cache_pkg::*; #(
    parameter int NUM_WAYS      = 4,
    parameter int ADDRESS_WIDTH = 32,
    parameter int BLOCK_SIZE    = 32,
    parameter int NUM_SETS      = 64
) ();
    localparam widths_t W       = calc_widths(ADDRESS_WIDTH, BLOCK_SIZE, NUM_SETS);
    localparam int      INDEX_W = W.index_w;
    localparam int      TAG_W   = W.tag_w;

    logic                     req_valid;
    logic                     req_ready;
    logic [ADDRESS_WIDTH-1:0] req_addr;
    logic [TAG_W-1:0]         lk_tag;
    logic [INDEX_W-1:0]       lk_index;
    logic                     lk_hit;
    logic [NUM_WAYS-1:0]      lk_hit_way;
    logic [NUM_WAYS-1:0]      way_valid;
    logic                     mem_req_valid;
    logic                     mem_req_ready;
    logic [ADDRESS_WIDTH-1:0] mem_req_addr;
    logic                     mem_resp_valid;
    logic                     fill_en;
    logic [NUM_WAYS-1:0]      fill_way;
    logic                     resp_valid;
    logic                     resp_hit;
    logic [NUM_WAYS-1:0]      resp_way;

    modport master (
        input  req_valid, req_addr, lk_hit, lk_hit_way, way_valid, mem_req_ready, mem_resp_valid,
        output req_ready, lk_tag, lk_index, mem_req_valid, mem_req_addr, fill_en, fill_way,
               resp_valid, resp_hit, resp_way
    );

    modport slave (
        output req_valid, req_addr, lk_hit, lk_hit_way, way_valid, mem_req_ready, mem_resp_valid,
        input  req_ready, lk_tag, lk_index, mem_req_valid, mem_req_addr, fill_en, fill_way,
               resp_valid, resp_hit, resp_way
    );
endinterface

// File: rtl/victim_select.sv
// victim_select: lowest-index invalid way, or the round-robin way when the
// whole set is valid.
module victim_select #(
    parameter int NUM_WAYS = 4
) (
    input  logic [NUM_WAYS-1:0]         i_way_valid,
    input  logic [$clog2(NUM_WAYS)-1:0] i_rr_ptr,
    output logic [NUM_WAYS-1:0]         o_victim,
    output logic                        o_used_rr
);
    logic [NUM_WAYS-1:0] w_free;

    // isolates the lowest zero bit of way_valid
    assign w_free    = ~i_way_valid & (i_way_valid + NUM_WAYS'(1));
    assign o_used_rr = &i_way_valid;
    assign o_victim  = o_used_rr ? NUM_WAYS'(1) << i_rr_ptr : w_free;
endmodule

// File: rtl/cache_access_ctrl.sv
// cache_access_ctrl: accepts one read at a time, drives the way lookup, and on
// a miss fetches the block, fills a victim way and responds.
module cache_access_ctrl import cache_pkg::*; #(
    parameter int NUM_WAYS      = 4,
    parameter int ADDRESS_WIDTH = 32,
    parameter int BLOCK_SIZE    = 32,
    parameter int NUM_SETS      = 64
) (
    input logic                 clk,
    input logic                 reset,
    cache_access_ctrl_if.master bus
);
    localparam widths_t W        = calc_widths(ADDRESS_WIDTH, BLOCK_SIZE, NUM_SETS);
    localparam int      OFFSET_W = W.offset_w;
    localparam int      INDEX_W  = W.index_w;
    localparam int      TAG_W    = W.tag_w;
    localparam int      RR_W     = $clog2(NUM_WAYS);

    state_e                   r_state;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [RR_W-1:0]          r_rr_ptr;
    logic                     r_req_ready;
    logic                     r_mem_req_valid;
    logic                     r_fill_en;
    logic [NUM_WAYS-1:0]      r_fill_way;
    logic                     r_resp_valid;
    logic                     r_resp_hit;
    logic [NUM_WAYS-1:0]      r_resp_way;
    logic [NUM_WAYS-1:0]      w_victim;
    logic                     w_used_rr;
    logic                     w_unused;

    victim_select #(.NUM_WAYS(NUM_WAYS)) u_victim (
        .i_way_valid(bus.way_valid),
        .i_rr_ptr   (r_rr_ptr),
        .o_victim   (w_victim),
        .o_used_rr  (w_used_rr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= IDLE;
            r_addr          <= '0;
            r_rr_ptr        <= '0;
            r_req_ready     <= 1'b1;
            r_mem_req_valid <= 1'b0;
            r_fill_en       <= 1'b0;
            r_fill_way      <= '0;
            r_resp_valid    <= 1'b0;
            r_resp_hit      <= 1'b0;
            r_resp_way      <= '0;
        end else begin
            r_fill_en    <= 1'b0;
            r_resp_valid <= 1'b0;
            case (r_state)
                IDLE: if (bus.req_valid) begin
                    r_addr      <= bus.req_addr;
                    r_req_ready <= 1'b0;
                    r_state     <= LOOKUP;
                end
                LOOKUP: if (bus.lk_hit) begin
                    r_resp_way   <= bus.lk_hit_way;
                    r_resp_hit   <= 1'b1;
                    r_resp_valid <= 1'b1;
                    r_state      <= RESP;
                end else begin
                    r_fill_way      <= w_victim;
                    r_rr_ptr        <= w_used_rr ? r_rr_ptr + RR_W'(1) : r_rr_ptr;
                    r_mem_req_valid <= 1'b1;
                    r_state         <= MISS_REQ;
                end
                MISS_REQ: if (bus.mem_req_ready) begin
                    r_mem_req_valid <= 1'b0;
                    r_state         <= MISS_WAIT;
                end
                MISS_WAIT: if (bus.mem_resp_valid) begin
                    r_fill_en <= 1'b1;
                    r_state   <= FILL;
                end
                FILL: begin
                    r_resp_hit   <= 1'b0;
                    r_resp_way   <= r_fill_way;
                    r_resp_valid <= 1'b1;
                    r_state      <= RESP;
                end
                RESP: begin
                    r_req_ready <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // byte offset never leaves the block; fetches are block aligned
    assign w_unused          = ^r_addr[OFFSET_W-1:0];
    assign bus.req_ready     = r_req_ready;
    assign bus.lk_tag        = r_addr[ADDRESS_WIDTH-1 -: TAG_W];
    assign bus.lk_index      = r_addr[OFFSET_W +: INDEX_W];
    assign bus.mem_req_valid = r_mem_req_valid;
    assign bus.mem_req_addr  = {r_addr[ADDRESS_WIDTH-1:OFFSET_W], OFFSET_W'(0)};
    assign bus.fill_en       = r_fill_en;
    assign bus.fill_way      = r_fill_way;
    assign bus.resp_valid    = r_resp_valid;
    assign bus.resp_hit      = r_resp_hit;
    assign bus.resp_way      = r_resp_way;

    a_hit_way_onehot: assert property (@(posedge clk) disable iff (reset)
        (r_state == LOOKUP && bus.lk_hit) |-> $onehot(bus.lk_hit_way));
endmodule

// File: tb/tb_cache_access_ctrl.sv
// tb_cache_access_ctrl: directed requests; expected responses and fills are
// queued at issue time and compared by a separate output monitor.
module tb_cache_access_ctrl;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int acc_cyc  = 0;
    int acc_prev = 0;
    logic [4:0] exp_q[$];
    logic [3:0] fill_q[$];

    cache_access_ctrl_if bus();
    cache_access_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (bus.resp_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL resp_unexpected: got resp_valid hit=%b way=%b, expected no response", bus.resp_hit, bus.resp_way);
            end else chk("resp_hit_way", {bus.resp_hit, bus.resp_way}, exp_q.pop_front());
        end
        if (bus.fill_en) begin
            if (fill_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL fill_unexpected: got fill_en way=%b, expected no fill", bus.fill_way);
            end else chk("fill_way", bus.fill_way, fill_q.pop_front());
        end
    end

    task automatic wait_ready();
        int k = 0;
        while (!bus.req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("req_ready_wait", bus.req_ready, 1);
    endtask

    task automatic do_req(input logic [31:0] addr, input logic hit, input logic [3:0] hway,
                          input logic [3:0] wv, input logic [3:0] way, input logic [20:0] tag,
                          input logic [5:0] idx, input int stall, input bit early);
        wait_ready();
        bus.req_valid  = 1'b1;
        bus.req_addr   = addr;
        bus.lk_hit     = hit;
        bus.lk_hit_way = hway;
        bus.way_valid  = wv;
        exp_q.push_back({hit, way});
        if (!hit) fill_q.push_back(way);
        @(posedge clk);
        acc_prev = acc_cyc;
        acc_cyc  = cyc;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("lk_tag", bus.lk_tag, tag);
        chk("lk_index", bus.lk_index, idx);
        chk("req_ready_busy", bus.req_ready, 0);
        if (!hit) begin
            @(negedge clk);
            for (int i = 0; i <= stall; i++) begin
                chk("mem_req_valid", bus.mem_req_valid, 1);
                chk("mem_req_addr", bus.mem_req_addr, addr & 32'hFFFF_FFE0);
                chk("no_fill_stall", bus.fill_en, 0);
                if (i < stall) @(negedge clk);
            end
            bus.mem_req_ready  = 1'b1;
            bus.mem_resp_valid = early;
            @(negedge clk);
            bus.mem_req_ready  = 1'b0;
            bus.mem_resp_valid = 1'b0;
            chk("mem_req_dropped", bus.mem_req_valid, 0);
            repeat (2) begin
                @(negedge clk);
                chk("fill_wait", bus.fill_en, 0);
            end
            bus.mem_resp_valid = 1'b1;
            @(negedge clk);
            bus.mem_resp_valid = 1'b0;
            chk("fill_en", bus.fill_en, 1);
        end
        @(negedge clk);
        chk("resp_valid_latency", bus.resp_valid, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        bus.req_valid      = 1'b0;
        bus.req_addr       = '0;
        bus.lk_hit         = 1'b0;
        bus.lk_hit_way     = '0;
        bus.way_valid      = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_mem_req_valid", bus.mem_req_valid, 0);
        chk("rst_mem_req_addr", bus.mem_req_addr, 0);
        chk("rst_fill_en", bus.fill_en, 0);
        chk("rst_fill_way", bus.fill_way, 0);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_resp_hit_way", {bus.resp_hit, bus.resp_way}, 0);
        chk("rst_lk", {bus.lk_tag, bus.lk_index}, 0);
        reset = 1'b0;

        do_req(32'h0000_1040, 1'b1, 4'b0100, 4'b1111, 4'b0100, 21'h2, 6'd2, 0, 1'b0);
        do_req(32'h0000_1040, 1'b0, 4'b0000, 4'b1011, 4'b0100, 21'h2, 6'd2, 5, 1'b1);

        // reset while waiting for memory: round-robin pointer also restarts
        wait_ready();
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_3000;
        bus.lk_hit    = 1'b0;
        bus.way_valid = 4'b1111;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("rst_test_mem_req_valid", bus.mem_req_valid, 1);
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_req_ready", bus.req_ready, 1);
        chk("midrst_mem_req_valid", bus.mem_req_valid, 0);
        chk("midrst_fill_en", bus.fill_en, 0);
        chk("midrst_resp_valid", bus.resp_valid, 0);
        bus.mem_resp_valid = 1'b1;
        @(negedge clk);
        bus.mem_resp_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("late_resp_no_fill", bus.fill_en, 0);
            chk("late_resp_no_resp", bus.resp_valid, 0);
            chk("late_resp_idle", bus.req_ready, 1);
        end

        do_req(32'h0000_2000, 1'b0, 4'b0000, 4'b1111, 4'b0001, 21'h4, 6'd0, 0, 1'b0);
        do_req(32'h0001_0FE0, 1'b0, 4'b0000, 4'b1111, 4'b0010, 21'h21, 6'd63, 1, 1'b0);
        do_req(32'h8000_0020, 1'b0, 4'b0000, 4'b1111, 4'b0100, 21'h100000, 6'd1, 0, 1'b0);
        do_req(32'h0000_07E0, 1'b0, 4'b0000, 4'b1111, 4'b1000, 21'h0, 6'd63, 2, 1'b0);
        do_req(32'h1234_5678, 1'b0, 4'b0000, 4'b1111, 4'b0001, 21'h2468A, 6'd51, 0, 1'b0);

        do_req(32'h0000_0000, 1'b1, 4'b0001, 4'b1111, 4'b0001, 21'h0, 6'd0, 0, 1'b0);
        do_req(32'hFFFF_FFFF, 1'b1, 4'b1000, 4'b1111, 4'b1000, 21'h1FFFFF, 6'd63, 0, 1'b0);
        chk("b2b_period", acc_cyc - acc_prev, 3);

        repeat (3) @(negedge clk);
        chk("resp_q_drained", exp_q.size(), 0);
        chk("fill_q_drained", fill_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
